// File: rtl/imm16_seq_pkg.sv
// Shared types and constants for the CPU micro-sequencers: state and T-state
// encodings, opcode patterns and register-pair codes.
package cpu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2,
        INT   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } tstate_t;

    typedef enum logic {
        OP_LD = 1'b0,
        OP_JP = 1'b1
    } imm_op_t;

    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_SP = 2'd3
    } pair_t;

    localparam logic [7:0] OP_LD_DD_NN_MASK = 8'hCF;
    localparam logic [7:0] OP_LD_DD_NN      = 8'h01;
    localparam logic [7:0] OP_JP_NN         = 8'hC3;

    function automatic logic is_ld_dd_nn(input logic [7:0] op);
        return (op & OP_LD_DD_NN_MASK) == OP_LD_DD_NN;
    endfunction

endpackage

// File: rtl/imm16_seq_if.sv
// Decoder / bus / register-file signals of the 16-bit immediate sequencer.
// The sequencer uses the slave side; the surrounding CPU drives the master side.
interface imm16_seq_if;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  din;
    logic        rd;
    logic        adr_pc;
    logic        pc_inc;
    logic        pc_load;
    logic        reg_we;
    logic [1:0]  reg_sel;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        unsup;

    modport master (
        output start, opcode, din,
        input  rd, adr_pc, pc_inc, pc_load, reg_we, reg_sel, wdata, busy, done, unsup
    );

    modport slave (
        input  start, opcode, din,
        output rd, adr_pc, pc_inc, pc_load, reg_we, reg_sel, wdata, busy, done, unsup
    );
endinterface

// File: rtl/imm16_seq_tstate_ctr.sv
// Generic T-state counter for multi-cycle sequencers: counts T1..T4 and
// returns to T1 on the clock after restart is seen.
module tstate_ctr
    import cpu_seq_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    restart,
    output tstate_t t,
    output logic    t4
);

    tstate_t t_q, t_d;

    always_comb begin
        t_d = restart ? T1 : tstate_t'(t_q + 2'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q <= T1;
        end else begin
            t_q <= t_d;
        end
    end

    assign t  = t_q;
    assign t4 = (t_q == T4);

endmodule

// File: rtl/imm16_seq.sv
// Micro-sequencer for LD dd,nn and JP nn: runs the two operand reads from PC
// and the register-pair or PC write-back after the M1 fetch.
//
//   state | meaning
//   IDLE  | waiting for start from M1 T4
//   RD_LO | M2: read low operand byte, then PC+1
//   RD_HI | M3: read high operand byte, then PC+1 (LD writes the pair here)
//   INT   | M4: internal cycle for JP, PC load at T4
module imm16_seq
    import cpu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    imm16_seq_if.slave bus
);

    seq_state_t state_q, state_d;
    imm_op_t    op_q, op_d;
    pair_t      sel_q, sel_d;
    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic       unsup_q, unsup_d;

    tstate_t t;
    logic    t4;
    logic    restart;
    logic    rd, pc_inc, reg_we, pc_load, done, accept;

    // Every state entry comes either from IDLE or from a T4, so this restarts at each entry.
    assign restart = (state_q == IDLE) || t4;

    tstate_ctr u_tctr (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .t       (t),
        .t4      (t4)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sel_d   = sel_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        unsup_d = 1'b0;
        rd      = 1'b0;
        pc_inc  = 1'b0;
        reg_we  = 1'b0;
        pc_load = 1'b0;
        done    = 1'b0;

        case (state_q)
            RD_LO: begin
                rd     = (t != T4);
                pc_inc = t4;
                if (t == T3) lo_d = bus.din;
                if (t4) state_d = RD_HI;
            end
            RD_HI: begin
                rd     = (t != T4);
                pc_inc = t4;
                if (t == T3) hi_d = bus.din;
                if (t4) begin
                    if (op_q == OP_LD) begin
                        reg_we  = 1'b1;
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = INT;
                    end
                end
            end
            INT: begin
                if (t4) begin
                    pc_load = 1'b1;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // The done clock doubles as M1 T4 of the next instruction.
        accept = bus.start && ((state_q == IDLE) || done);
        if (accept) begin
            if (is_ld_dd_nn(bus.opcode)) begin
                op_d    = OP_LD;
                sel_d   = pair_t'(bus.opcode[5:4]);
                state_d = RD_LO;
            end else if (bus.opcode == OP_JP_NN) begin
                op_d    = OP_JP;
                state_d = RD_LO;
            end else begin
                unsup_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_LD;
            sel_q   <= PAIR_BC;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            unsup_q <= unsup_d;
        end
    end

    assign bus.rd      = rd;
    assign bus.adr_pc  = rd;
    assign bus.pc_inc  = pc_inc;
    assign bus.pc_load = pc_load;
    assign bus.reg_we  = reg_we;
    assign bus.reg_sel = sel_q;
    assign bus.wdata   = {hi_q, lo_q};
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done;
    assign bus.unsup   = unsup_q;

endmodule

// File: tb/tb_imm16_seq.sv
// Self-checking bench for imm16_seq: directed vector table, hand-built
// multi-cycle sequences and random traffic against a timeline reference model.
module tb_imm16_seq;

    logic clk = 1'b0;
    logic reset;

    imm16_seq_if bus ();

    imm16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    bit chk_en = 1'b0;

    // Reference model: position inside the current instruction, counted in clocks after start.
    int         m_rel   = 0;
    int         m_len   = 0;
    bit         m_jp    = 1'b0;
    logic [7:0] m_lo    = 8'h00;
    logic [7:0] m_hi    = 8'h00;
    logic [1:0] m_sel   = 2'd0;
    bit         m_unsup = 1'b0;

    int          obs_rel, obs_done_rel, obs_done_cnt, obs_unsup_rel;
    int          obs_we, obs_load, obs_inc, obs_busy;
    logic [15:0] obs_wd;
    logic [1:0]  obs_sel;

    logic       st_at  [32];
    logic [7:0] op_at  [32];
    logic [7:0] din_at [32];
    logic       rst_at [32];

    typedef struct {
        logic [7:0]  op;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          done_rel;
        int          we;
        int          load;
        int          inc;
        int          busy;
        int          unsup_rel;
        logic [1:0]  sel;
        logic [15:0] wd;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h want %0h", name, cyc_n, got, want);
        end
    endtask

    task automatic cyc(input logic s, input logic [7:0] op, input logic [7:0] d, input logic r);
        bit fin;
        bus.start  = s;
        bus.opcode = op;
        bus.din    = d;
        reset      = r;
        @(negedge clk);
        if (chk_en) begin
            chk("busy",    32'(bus.busy),    32'(m_rel > 0));
            chk("rd",      32'(bus.rd),      32'(m_rel inside {1, 2, 3, 5, 6, 7}));
            chk("adr_pc",  32'(bus.adr_pc),  32'(m_rel inside {1, 2, 3, 5, 6, 7}));
            chk("pc_inc",  32'(bus.pc_inc),  32'(m_rel == 4 || m_rel == 8));
            chk("reg_we",  32'(bus.reg_we),  32'(!m_jp && m_rel == 8));
            chk("pc_load", 32'(bus.pc_load), 32'(m_jp && m_rel == 12));
            chk("done",    32'(bus.done),    32'(m_rel != 0 && m_rel == m_len));
            chk("unsup",   32'(bus.unsup),   32'(m_unsup));
            chk("reg_sel", 32'(bus.reg_sel), 32'(m_sel));
            chk("wdata",   32'(bus.wdata),   32'({m_hi, m_lo}));
        end
        if (bus.done) begin
            obs_done_cnt++;
            obs_done_rel = obs_rel;
            obs_wd       = bus.wdata;
            obs_sel      = bus.reg_sel;
        end
        if (bus.unsup && obs_unsup_rel < 0) obs_unsup_rel = obs_rel;
        if (bus.reg_we)  obs_we++;
        if (bus.pc_load) obs_load++;
        if (bus.pc_inc)  obs_inc++;
        if (bus.busy)    obs_busy++;

        if (r) begin
            m_rel = 0; m_len = 0; m_jp = 1'b0;
            m_lo = 8'h00; m_hi = 8'h00; m_sel = 2'd0; m_unsup = 1'b0;
        end else begin
            fin = (m_rel != 0) && (m_rel == m_len);
            if (m_rel == 3) m_lo = d;
            if (m_rel == 7) m_hi = d;
            m_unsup = 1'b0;
            if (s && (m_rel == 0 || fin)) begin
                if ((op & 8'hCF) == 8'h01) begin
                    m_rel = 1; m_len = 8; m_jp = 1'b0; m_sel = op[5:4];
                end else if (op == 8'hC3) begin
                    m_rel = 1; m_len = 12; m_jp = 1'b1;
                end else begin
                    m_unsup = 1'b1; m_rel = 0;
                end
            end else if (fin) begin
                m_rel = 0;
            end else if (m_rel != 0) begin
                m_rel++;
            end
        end
        cyc_n++;
        obs_rel++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_window();
        for (int i = 0; i < 32; i++) begin
            st_at[i]  = 1'b0;
            op_at[i]  = 8'($urandom);
            din_at[i] = 8'($urandom);
            rst_at[i] = 1'b0;
        end
    endtask

    task automatic drive_window(input int n);
        obs_rel = 0; obs_done_rel = -1; obs_done_cnt = 0; obs_unsup_rel = -1;
        obs_we = 0; obs_load = 0; obs_inc = 0; obs_busy = 0;
        obs_wd = 16'h0; obs_sel = 2'd0;
        for (int i = 0; i < n; i++) cyc(st_at[i], op_at[i], din_at[i], rst_at[i]);
    endtask

    initial begin
        logic       s, r;
        logic [7:0] op;

        vecs[0] = '{8'h01, 8'h34, 8'h12,  8, 1, 0, 2,  8, -1, 2'd0, 16'h1234};
        vecs[1] = '{8'h31, 8'hEF, 8'hBE,  8, 1, 0, 2,  8, -1, 2'd3, 16'hBEEF};
        vecs[2] = '{8'hC3, 8'h00, 8'h80, 12, 0, 1, 2, 12, -1, 2'd3, 16'h8000};
        vecs[3] = '{8'h11, 8'hAA, 8'h55,  8, 1, 0, 2,  8, -1, 2'd1, 16'h55AA};
        vecs[4] = '{8'h21, 8'h01, 8'h02,  8, 1, 0, 2,  8, -1, 2'd2, 16'h0201};
        vecs[5] = '{8'h00, 8'h00, 8'h00, -1, 0, 0, 0,  0,  1, 2'd0, 16'h0000};
        vecs[6] = '{8'h76, 8'h00, 8'h00, -1, 0, 0, 0,  0,  1, 2'd0, 16'h0000};
        vecs[7] = '{8'hC2, 8'h00, 8'h00, -1, 0, 0, 0,  0,  1, 2'd0, 16'h0000};
        vecs[8] = '{8'h41, 8'h00, 8'h00, -1, 0, 0, 0,  0,  1, 2'd0, 16'h0000};

        bus.start = 1'b0; bus.opcode = 8'h00; bus.din = 8'h00; reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 8'h00, 8'h00, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 8'h00, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 9; i++) begin
            clear_window();
            st_at[0]  = 1'b1;
            op_at[0]  = vecs[i].op;
            din_at[3] = vecs[i].lo;
            din_at[7] = vecs[i].hi;
            drive_window(15);
            chk("vec_done_rel",  obs_done_rel,  vecs[i].done_rel);
            chk("vec_reg_we",    obs_we,        vecs[i].we);
            chk("vec_pc_load",   obs_load,      vecs[i].load);
            chk("vec_pc_inc",    obs_inc,       vecs[i].inc);
            chk("vec_busy_clks", obs_busy,      vecs[i].busy);
            chk("vec_unsup_rel", obs_unsup_rel, vecs[i].unsup_rel);
            if (vecs[i].done_rel >= 0) begin
                chk("vec_sel",   32'(obs_sel), 32'(vecs[i].sel));
                chk("vec_wdata", 32'(obs_wd),  32'(vecs[i].wd));
            end
        end

        // LD HL,nn cut short by reset at clock 6, then LD DE,nn runs clean
        clear_window();
        st_at[0] = 1'b1; op_at[0] = 8'h21;
        din_at[3] = 8'h5A; din_at[7] = 8'h6B;
        rst_at[6] = 1'b1;
        drive_window(12);
        chk("rst_reg_we",  obs_we,       0);
        chk("rst_pc_load", obs_load,     0);
        chk("rst_done",    obs_done_cnt, 0);
        chk("rst_busy",    obs_busy,     6);
        chk("rst_pc_inc",  obs_inc,      1);
        clear_window();
        st_at[0] = 1'b1; op_at[0] = 8'h11;
        din_at[3] = 8'hC4; din_at[7] = 8'h3B;
        drive_window(12);
        chk("post_rst_done_rel", obs_done_rel, 8);
        chk("post_rst_wdata",    32'(obs_wd),  32'h3BC4);
        chk("post_rst_sel",      32'(obs_sel), 32'd1);
        chk("post_rst_reg_we",   obs_we,       1);

        // LD then LD started in the done clock; starts while busy are ignored
        clear_window();
        st_at[0] = 1'b1;  op_at[0] = 8'h01;  din_at[3] = 8'hA1;  din_at[7] = 8'hB2;
        st_at[4] = 1'b1;  op_at[4] = 8'h00;
        st_at[8] = 1'b1;  op_at[8] = 8'h11;  din_at[11] = 8'hC3; din_at[15] = 8'hD4;
        st_at[12] = 1'b1; op_at[12] = 8'hC3;
        drive_window(20);
        chk("b2b_done_cnt",  obs_done_cnt,  2);
        chk("b2b_done_rel",  obs_done_rel,  16);
        chk("b2b_reg_we",    obs_we,        2);
        chk("b2b_pc_load",   obs_load,      0);
        chk("b2b_pc_inc",    obs_inc,       4);
        chk("b2b_busy",      obs_busy,      16);
        chk("b2b_unsup_rel", obs_unsup_rel, -1);
        chk("b2b_wdata",     32'(obs_wd),   32'hD4C3);
        chk("b2b_sel",       32'(obs_sel),  32'd1);

        // JP then LD SP,nn started in the JP done clock
        clear_window();
        st_at[0] = 1'b1;  op_at[0] = 8'hC3;  din_at[3] = 8'h11;  din_at[7] = 8'h22;
        st_at[12] = 1'b1; op_at[12] = 8'h31; din_at[15] = 8'h33; din_at[19] = 8'h44;
        drive_window(24);
        chk("jp2ld_done_cnt", obs_done_cnt, 2);
        chk("jp2ld_done_rel", obs_done_rel, 20);
        chk("jp2ld_pc_load",  obs_load,     1);
        chk("jp2ld_reg_we",   obs_we,       1);
        chk("jp2ld_pc_inc",   obs_inc,      4);
        chk("jp2ld_busy",     obs_busy,     20);
        chk("jp2ld_wdata",    32'(obs_wd),  32'h4433);
        chk("jp2ld_sel",      32'(obs_sel), 32'd3);

        for (int i = 0; i < 500; i++) begin
            s = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       op = 8'h01;
                1:       op = 8'h11;
                2:       op = 8'h21;
                3:       op = 8'h31;
                4:       op = 8'hC3;
                default: op = 8'($urandom);
            endcase
            r = ($urandom_range(0, 63) == 0);
            cyc(s, op, 8'($urandom), r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
